// File: rtl/fmul_sched.sv
// fmul_sched: round-robin scheduler sharing one fixed-latency pipelined multiplier
// among NREQ requesters, with credit-based issue into a shared response FIFO.
module fmul_sched #(
    parameter int NREQ     = 4,
    parameter int IDW      = 2,
    parameter int FMUL_LAT = 3,
    parameter int DEPTH    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_rs1,
    input  logic [32*NREQ-1:0]   req_rs2,
    output logic [31:0]          fmul_rs1,
    output logic [31:0]          fmul_rs2,
    input  logic [31:0]          fmul_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic [2:0]           inflight,
    output logic                 busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 1;

    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [IDW-1:0]      grant, lo_g, hi_g;
    logic                lo_f, hi_f;
    logic                can_issue, transfer;
    logic [SW-1:0]       credit_sum;

    logic [FMUL_LAT-1:0] v_q;
    logic [FMUL_LAT-1:0] sign_q;
    logic [IDW-1:0]      id_q [FMUL_LAT];
    logic [2:0]          inflight_q;

    logic [31:0]         mem_q [DEPTH];
    logic [IDW-1:0]      rid_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q;
    logic                push, pop;

    // The multiplier's sign output is not aligned with its magnitude; the pipe supplies it.
    logic                unused_fmul_sign;
    assign unused_fmul_sign = fmul_out[31];

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // First requester at or above ptr wins; otherwise wrap to the lowest one.
    always_comb begin
        lo_g = '0;
        hi_g = '0;
        lo_f = 1'b0;
        hi_f = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_g = IDW'(i);
                lo_f = 1'b1;
                if (i >= int'(ptr_q)) begin
                    hi_g = IDW'(i);
                    hi_f = 1'b1;
                end
            end
        end
        grant = hi_f ? hi_g : lo_g;
    end

    // Credit uses registered state only: a same-cycle pop earns nothing until next cycle.
    assign credit_sum = SW'(count_q) + SW'(inflight_q);
    assign can_issue  = credit_sum < SW'(DEPTH);
    assign transfer   = lo_f & can_issue & ~reset;

    always_comb begin
        req_ready = '0;
        fmul_rs1  = '0;
        fmul_rs2  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (transfer && grant == IDW'(i)) begin
                req_ready[i] = 1'b1;
                fmul_rs1     = req_rs1[32*i +: 32];
                fmul_rs2     = req_rs2[32*i +: 32];
            end
        end
    end

    assign ptr_d = !transfer ? ptr_q :
                   (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;

    assign push      = v_q[FMUL_LAT-1];
    assign rsp_valid = (count_q != '0);
    assign pop       = rsp_valid & rsp_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q      <= '0;
            v_q        <= '0;
            sign_q     <= '0;
            inflight_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int s = 0; s < FMUL_LAT; s++) id_q[s] <= '0;
        end else begin
            ptr_q     <= ptr_d;
            v_q[0]    <= transfer;
            id_q[0]   <= grant;
            sign_q[0] <= fmul_rs1[31] ^ fmul_rs2[31];
            for (int s = 1; s < FMUL_LAT; s++) begin
                v_q[s]    <= v_q[s-1];
                id_q[s]   <= id_q[s-1];
                sign_q[s] <= sign_q[s-1];
            end
            inflight_q <= inflight_q + 3'(transfer) - 3'(push);
            if (push) wr_ptr_q <= wrap_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= wrap_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {sign_q[FMUL_LAT-1], fmul_out[30:0]};
            rid_q[wr_ptr_q] <= id_q[FMUL_LAT-1];
        end
    end

    assign rsp_data = mem_q[rd_ptr_q];
    assign rsp_id   = rid_q[rd_ptr_q];
    assign inflight = inflight_q;
    assign busy     = (inflight_q != '0) | rsp_valid;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
                                    !(push && count_q == CW'(DEPTH)));

endmodule

// File: tb/tb_fmul_sched.sv
// Testbench for fmul_sched: mock 3-stage multiplier, queue-based reference model,
// directed vector table, hand-written corner sequences and a randomized phase.
module tb_fmul_sched;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int LAT   = 3;
    localparam int DEPTH = 8;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_rs1, req_rs2;
    logic [31:0]         fmul_rs1, fmul_rs2, fmul_out;
    logic                rsp_valid, rsp_ready;
    logic [31:0]         rsp_data;
    logic [IDW-1:0]      rsp_id;
    logic [2:0]          inflight;
    logic                busy;

    fmul_sched #(.NREQ(NREQ), .IDW(IDW), .FMUL_LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .fmul_rs1(fmul_rs1), .fmul_rs2(fmul_rs2), .fmul_out(fmul_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id),
        .inflight(inflight), .busy(busy)
    );

    always #5 clk = ~clk;

    // Truncating single-precision magnitude product for normal inputs.
    function automatic logic [30:0] fmag(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        logic [9:0]  e;
        logic [22:0] f;
        m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
        if (m[47]) begin
            f = m[46:24];
            e = e + 10'd1;
        end else begin
            f = m[45:23];
        end
        return {e[7:0], f};
    endfunction

    // Mock multiplier: correct magnitude after LAT cycles, deliberately wrong sign bit.
    logic [31:0] mstage [LAT];
    always @(posedge clk) begin
        mstage[0] <= {~(fmul_rs1[31] ^ fmul_rs2[31]), fmag(fmul_rs1, fmul_rs2)};
        for (int s = 1; s < LAT; s++) mstage[s] <= mstage[s-1];
    end
    assign fmul_out = mstage[LAT-1];

    typedef struct {
        int          t;
        logic [IDW-1:0] id;
        logic [31:0] data;
    } op_t;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expd;
    } vec_t;

    op_t             expq[$];
    int              mptr = 0;
    int              cyc = 0;
    int              ncmp = 0;
    int              nbad = 0;
    logic [NREQ-1:0] acc = '0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
        ncmp++;
        if (act !== expv) begin
            nbad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    // One clock: check DUT against the model mid-cycle, update the model, return after the edge.
    task automatic tick();
        logic [NREQ-1:0] er;
        logic [31:0]     e1, e2;
        int              g, nin;
        logic            erv;
        op_t             o;
        @(negedge clk);
        acc = req_valid & req_ready;
        if (reset) begin
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("rst_inflight", 32'(inflight), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_fmul_rs1", fmul_rs1, 32'd0);
            check("rst_fmul_rs2", fmul_rs2, 32'd0);
            expq.delete();
            mptr = 0;
        end else begin
            er = '0;
            g  = -1;
            if (expq.size() < DEPTH) begin
                for (int k = 0; k < NREQ; k++) begin
                    int idx;
                    idx = (mptr + k) % NREQ;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            if (g >= 0) er[g] = 1'b1;
            e1 = (g >= 0) ? req_rs1[32*g +: 32] : 32'd0;
            e2 = (g >= 0) ? req_rs2[32*g +: 32] : 32'd0;
            check("req_ready", 32'(req_ready), 32'(er));
            check("fmul_rs1", fmul_rs1, e1);
            check("fmul_rs2", fmul_rs2, e2);
            nin = 0;
            foreach (expq[j]) if (cyc - expq[j].t >= 1 && cyc - expq[j].t <= LAT) nin++;
            erv = (expq.size() > 0) && (cyc >= expq[0].t + LAT + 1);
            check("inflight", 32'(inflight), 32'(nin));
            check("rsp_valid", 32'(rsp_valid), 32'(erv));
            check("busy", 32'(busy), 32'((nin != 0) || erv));
            if (erv) begin
                check("rsp_data", rsp_data, expq[0].data);
                check("rsp_id", 32'(rsp_id), 32'(expq[0].id));
                if (rsp_ready) void'(expq.pop_front());
            end
            if (g >= 0) begin
                o.t    = cyc;
                o.id   = IDW'(g);
                o.data = {e1[31] ^ e2[31], fmag(e1, e2)};
                expq.push_back(o);
                mptr = (g + 1) % NREQ;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input int pct);
        for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] || acc[i]) begin
                req_valid[i]        = (int'($urandom_range(99)) < pct);
                req_rs1[32*i +: 32] = $urandom();
                req_rs2[32*i +: 32] = $urandom();
            end
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic single_op(input vec_t v, input string tag);
        int lat;
        lat = -1;
        req_valid = '0;
        req_valid[v.id] = 1'b1;
        req_rs1[32*v.id +: 32] = v.a;
        req_rs2[32*v.id +: 32] = v.b;
        rsp_ready = 1'b1;
        tick();
        check({tag, "_accept"}, 32'(acc[v.id]), 32'd1);
        req_valid = '0;
        for (int k = 1; k <= 8 && lat < 0; k++) begin
            if (rsp_valid) begin
                lat = k;
                check({tag, "_data"}, rsp_data, v.expd);
                check({tag, "_id"}, 32'(rsp_id), 32'(v.id));
            end else begin
                tick();
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[4];
        int          n, extra;
        logic [31:0] rd[2];
        int          ri[2];

        vt[0] = '{0, 32'h40400000, 32'h40000000, 32'h40C00000};
        vt[1] = '{3, 32'hBFC00000, 32'h40000000, 32'hC0400000};
        vt[2] = '{1, 32'hC0400000, 32'hC0000000, 32'h40C00000};
        vt[3] = '{2, 32'h3F800000, 32'h3F800000, 32'h3F800000};

        req_valid = '0;
        req_rs1   = '0;
        req_rs2   = '0;
        rsp_ready = 1'b0;
        do_reset();

        // Idle: model checks zero operands, inflight, busy and an unchanged pointer.
        for (int k = 0; k < 4; k++) tick();

        foreach (vt[i]) single_op(vt[i], $sformatf("vec%0d", i));

        // Sign tracking: req1 then req2 back-to-back, results returned in order.
        req_valid = 4'b0010;
        req_rs1[32*1 +: 32] = 32'h40400000;
        req_rs2[32*1 +: 32] = 32'h40000000;
        tick();
        check("sign_acc1", 32'(acc[1]), 32'd1);
        req_valid = 4'b0100;
        req_rs1[32*2 +: 32] = 32'hBFC00000;
        req_rs2[32*2 +: 32] = 32'h40000000;
        tick();
        check("sign_acc2", 32'(acc[2]), 32'd1);
        req_valid = '0;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            if (rsp_valid && n < 2) begin
                rd[n] = rsp_data;
                ri[n] = int'(rsp_id);
                n++;
            end
            tick();
        end
        check("sign_count", 32'(n), 32'd2);
        if (n == 2) begin
            check("sign_data0", rd[0], 32'h40C00000);
            check("sign_id0", 32'(ri[0]), 32'd1);
            check("sign_data1", rd[1], 32'hC0400000);
            check("sign_id1", 32'(ri[1]), 32'd2);
        end

        // Round-robin with every requester valid.
        do_reset();
        rsp_ready = 1'b1;
        drive(100);
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("rr_grant%0d", k), 32'(acc), 32'(1 << (k % NREQ)));
            drive(100);
        end
        req_valid = '0;
        for (int k = 0; k < 10; k++) tick();

        // Back-pressure: fill to DEPTH, one pop admits exactly one more grant.
        do_reset();
        rsp_ready = 1'b0;
        drive(100);
        n = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            n += $countones(acc);
            drive(100);
        end
        check("bp_transfers", 32'(n), 32'(DEPTH));
        check("bp_stalled", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        tick();
        extra = $countones(acc);
        drive(100);
        rsp_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            extra += $countones(acc);
            drive(100);
        end
        check("bp_extra", 32'(extra), 32'd1);
        check("bp_restalled", 32'(req_ready), 32'd0);
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 16; k++) tick();
        check("bp_drained", 32'(busy), 32'd0);

        // Reset with three ops in flight and two in the FIFO.
        do_reset();
        rsp_ready = 1'b0;
        drive(100);
        for (int k = 0; k < 5; k++) begin
            tick();
            drive(100);
        end
        check("mid_inflight", 32'(inflight), 32'd3);
        check("mid_rsp_valid", 32'(rsp_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_inflight", 32'(inflight), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_fmul_rs1", fmul_rs1, 32'd0);
        req_valid = '0;
        tick();
        tick();
        reset = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        single_op(vt[0], "post_rst");

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            rsp_ready = (int'($urandom_range(9)) < 7);
            drive(60);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        check("rand_drained", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
